// File: rtl/irig_usb_frame_sched_if.sv
// ---------------------------------------------------------------------------
// irig_usb_frame_sched_if
//   Byte-wide valid/ready stream from the IRIG-B frame scheduler to the USB
//   TX FIFO writer.
//
//   Signals:
//     tx_data   8  byte offered to the USB side
//     tx_valid  1  tx_data holds a byte waiting to be taken
//     tx_ready  1  USB side takes the byte on this edge
//
//   Modports:
//     master  scheduler side (drives tx_data/tx_valid, sees tx_ready)
//     slave   USB writer side (sees tx_data/tx_valid, drives tx_ready)
// ---------------------------------------------------------------------------
interface irig_usb_frame_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/irig_usb_frame_sched.sv
// ---------------------------------------------------------------------------
// irig_usb_frame_sched
//   Takes decoded IRIG-B time frames (FRAME_LEN bytes plus a one-cycle
//   frame_flag) and streams them onto the USB TX byte interface as
//   HDR0, HDR1, payload[0..FRAME_LEN-1] (and an XOR checksum byte when
//   IRIG_FRAME_CHECKSUM_EN is defined). One frame can wait in a pending
//   buffer while another is on the wire; further arrivals overwrite the
//   pending frame and bump a saturating drop counter. A watchdog raises
//   sig_lost when no frame has arrived for LOSS_CYCLES clocks.
//
//   Optional feature macro: IRIG_FRAME_CHECKSUM_EN
//     defined   -> CSUM state appends XOR(HDR0, HDR1, payload) after payload
//     undefined -> frame ends after the last payload byte
//
//   Ports:
//     clk          in   system clock (50 MHz)
//     rst_n        in   synchronous reset, active low
//     frame_array  in   FRAME_LEN payload bytes, valid while frame_flag=1
//     frame_flag   in   one-cycle pulse announcing a new frame
//     tx           if   master side of the byte stream (data/valid/ready)
//     busy         out  high whenever a frame is being sent
//     drop_cnt     out  saturating count of overwritten pending frames
//     sig_lost     out  no frame seen for LOSS_CYCLES cycles
// ---------------------------------------------------------------------------
module irig_usb_frame_sched #(
  parameter int          FRAME_LEN   = 25,
  parameter logic [7:0]  HDR0        = 8'hAA,
  parameter logic [7:0]  HDR1        = 8'h55,
  parameter logic [31:0] LOSS_CYCLES = 32'd75_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FRAME_LEN-1:0][7:0]   frame_array,
  input  logic                        frame_flag,
  irig_usb_frame_sched_if.master      tx,
  output logic                        busy,
  output logic [7:0]                  drop_cnt,
  output logic                        sig_lost
);

  localparam int                IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

`ifdef IRIG_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_BODY, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_BODY} state_t;
`endif

  state_t                     r_state;
  logic [IDX_W-1:0]           r_idx;
  logic [FRAME_LEN-1:0][7:0]  r_shadow;
  logic [FRAME_LEN-1:0][7:0]  r_pend;
  logic                       r_pend_vld;
  logic [7:0]                 r_drop_cnt;
  logic [31:0]                r_loss_cnt;
`ifdef IRIG_FRAME_CHECKSUM_EN
  logic [7:0]                 r_csum;
`endif

  state_t      w_next_state;
  logic        w_valid;
  logic        w_xfer;
  logic        w_frame_end;
  logic        w_load_flag;
  logic        w_load_pend;
  logic        w_store_pend;
  logic        w_drop;
  logic [7:0]  w_tx_data;

  // Next-state and buffer-control decode. w_load_flag / w_load_pend fire
  // exactly on entry to HDR0, either from IDLE or from the final transfer
  // of the previous frame, so back-to-back frames have no idle bubble.
  always_comb begin
    w_next_state = r_state;
    w_valid      = (r_state != S_IDLE);
    w_xfer       = w_valid && tx.tx_ready;
    w_frame_end  = 1'b0;
    w_load_flag  = 1'b0;
    w_load_pend  = 1'b0;
    w_store_pend = 1'b0;
    w_drop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (frame_flag) begin
          w_next_state = S_HDR0;
          w_load_flag  = 1'b1;
        end else if (r_pend_vld) begin
          w_next_state = S_HDR0;
          w_load_pend  = 1'b1;
        end
      end
      S_HDR0: if (w_xfer) w_next_state = S_HDR1;
      S_HDR1: if (w_xfer) w_next_state = S_BODY;
      S_BODY: begin
        if (w_xfer && (r_idx == LAST_IDX)) begin
`ifdef IRIG_FRAME_CHECKSUM_EN
          w_next_state = S_CSUM;
`else
          w_frame_end  = 1'b1;
`endif
        end
      end
`ifdef IRIG_FRAME_CHECKSUM_EN
      S_CSUM: if (w_xfer) w_frame_end = 1'b1;
`endif
      default: w_next_state = S_IDLE;
    endcase

    // A flag on the final-transfer edge goes straight into shadow and
    // leaves any pending frame untouched for the frame after.
    if (w_frame_end) begin
      if (frame_flag) begin
        w_next_state = S_HDR0;
        w_load_flag  = 1'b1;
      end else if (r_pend_vld) begin
        w_next_state = S_HDR0;
        w_load_pend  = 1'b1;
      end else begin
        w_next_state = S_IDLE;
      end
    end

    if (w_valid && frame_flag && !w_frame_end) begin
      w_store_pend = 1'b1;
      w_drop       = r_pend_vld;
    end
  end

  // Output byte mux; everything it selects from is frozen while a byte is
  // stalled, so tx_data stays stable until it transfers.
  always_comb begin
    w_tx_data = 8'h00;
    case (r_state)
      S_HDR0:  w_tx_data = HDR0;
      S_HDR1:  w_tx_data = HDR1;
      S_BODY:  w_tx_data = r_shadow[r_idx];
`ifdef IRIG_FRAME_CHECKSUM_EN
      S_CSUM:  w_tx_data = r_csum;
`endif
      default: w_tx_data = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: byte index, shadow/pending buffers, drop and loss counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_shadow   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_drop_cnt <= 8'h00;
      r_loss_cnt <= 32'd0;
    end else begin
      if (r_state == S_HDR1 && w_xfer) begin
        r_idx <= '0;
      end else if (r_state == S_BODY && w_xfer) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      if (w_load_flag) begin
        r_shadow <= frame_array;
      end else if (w_load_pend) begin
        r_shadow <= r_pend;
      end

      if (w_store_pend) begin
        r_pend     <= frame_array;
        r_pend_vld <= 1'b1;
      end else if (w_load_pend) begin
        r_pend_vld <= 1'b0;
      end

      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      if (frame_flag) begin
        r_loss_cnt <= 32'd0;
      end else if (r_loss_cnt != LOSS_CYCLES) begin
        r_loss_cnt <= r_loss_cnt + 32'd1;
      end
    end
  end

`ifdef IRIG_FRAME_CHECKSUM_EN
  // Running XOR of every byte sent in the frame; restarts on HDR0 entry,
  // which takes priority over the final transfer of the previous frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_csum <= 8'h00;
    end else if (w_load_flag || w_load_pend) begin
      r_csum <= 8'h00;
    end else if (w_xfer && (r_state != S_CSUM)) begin
      r_csum <= r_csum ^ w_tx_data;
    end
  end
`endif

  assign tx.tx_data  = w_tx_data;
  assign tx.tx_valid = w_valid;
  assign busy        = w_valid;
  assign drop_cnt    = r_drop_cnt;
  assign sig_lost    = (r_loss_cnt == LOSS_CYCLES);

endmodule

// File: tb/tb_irig_usb_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_irig_usb_frame_sched
//   Directed bench for irig_usb_frame_sched with LOSS_CYCLES = 100. Inputs
//   are driven 1 ns after the rising edge and outputs sampled at that point.
//   Every byte that transfers is logged and compared with a reference
//   frame built from the payload that was applied.
// ---------------------------------------------------------------------------
module tb_irig_usb_frame_sched;

  localparam int          FRAME_LEN = 25;
  localparam logic [31:0] LOSS      = 32'd100;
`ifdef IRIG_FRAME_CHECKSUM_EN
  localparam int          WIRE_LEN  = FRAME_LEN + 3;
`else
  localparam int          WIRE_LEN  = FRAME_LEN + 2;
`endif

  typedef logic [FRAME_LEN-1:0][7:0] payload_t;

  typedef struct {
    string       name;
    logic        useIndex;
    logic [7:0]  fill;
    logic [3:0]  readyPat;
    int          expCycles;
    logic [7:0]  expDrop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  payload_t    frameArray;
  logic        frameFlag;
  logic        busy;
  logic [7:0]  dropCnt;
  logic        sigLost;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [7:0]  rxQ[$];
  logic [7:0]  expQ[$];

  irig_usb_frame_sched_if txIf();

  irig_usb_frame_sched #(
    .FRAME_LEN   (FRAME_LEN),
    .HDR0        (8'hAA),
    .HDR1        (8'h55),
    .LOSS_CYCLES (LOSS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_array (frameArray),
    .frame_flag  (frameFlag),
    .tx          (txIf.master),
    .busy        (busy),
    .drop_cnt    (dropCnt),
    .sig_lost    (sigLost)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: log a transfer if one happens on this edge, and make sure a
  // stalled byte is still offered unchanged afterwards.
  task automatic stepRec();
    logic       stalled;
    logic [7:0] heldData;
    stalled  = txIf.tx_valid && !txIf.tx_ready;
    heldData = txIf.tx_data;
    if (txIf.tx_valid && txIf.tx_ready) rxQ.push_back(txIf.tx_data);
    @(posedge clk);
    #1;
    if (stalled) begin
      checkOutput("stall_valid", {31'd0, txIf.tx_valid}, 32'd1);
      checkOutput("stall_data", {24'd0, txIf.tx_data}, {24'd0, heldData});
    end
  endtask

  task automatic applyStimulus(input payload_t pl);
    frameArray = pl;
    frameFlag  = 1'b1;
    stepRec();
    frameFlag  = 1'b0;
    frameArray = {FRAME_LEN{8'hEE}};
  endtask

  task automatic runStream(input logic [3:0] pat, input int budget, output int cycles);
    int k;
    k = 0;
    while (txIf.tx_valid && k < budget) begin
      txIf.tx_ready = pat[k % 4];
      stepRec();
      k++;
    end
    cycles = k;
    txIf.tx_ready = 1'b1;
    checkOutput("stream_timeout", {31'd0, txIf.tx_valid}, 32'd0);
  endtask

  task automatic buildExp(input payload_t pl);
    logic [7:0] cs;
    cs = 8'hAA ^ 8'h55;
    expQ.push_back(8'hAA);
    expQ.push_back(8'h55);
    for (int i = 0; i < FRAME_LEN; i++) begin
      expQ.push_back(pl[i]);
      cs = cs ^ pl[i];
    end
`ifdef IRIG_FRAME_CHECKSUM_EN
    expQ.push_back(cs);
`endif
  endtask

  task automatic checkFrames(input string name);
    int n;
    checkOutput({name, "_len"}, rxQ.size(), expQ.size());
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_byte%0d", name, i), {24'd0, rxQ[i]}, {24'd0, expQ[i]});
    end
    rxQ.delete();
    expQ.delete();
  endtask

  task automatic doReset();
    rst_n         = 1'b0;
    frameFlag     = 1'b0;
    frameArray    = '0;
    txIf.tx_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rxQ.delete();
    expQ.delete();
    rst_n = 1'b1;
  endtask

  function automatic payload_t fillPayload(input logic useIndex, input logic [7:0] fill);
    payload_t p;
    for (int i = 0; i < FRAME_LEN; i++) p[i] = useIndex ? 8'(i) : fill;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t     vecs[4];
    payload_t pl;
    payload_t p11, p22, p33, p5a;
    int       cyc;
    logic [7:0] dropBefore;

    vecs[0] = '{"single_idx",  1'b1, 8'h00, 4'b1111, WIRE_LEN, 8'd0};
    vecs[1] = '{"bp_1001",     1'b1, 8'h00, 4'b1001, 0,        8'd0};
    vecs[2] = '{"fill_ff",     1'b0, 8'hFF, 4'b1111, WIRE_LEN, 8'd0};
    vecs[3] = '{"bp_alt_01",   1'b0, 8'h01, 4'b0101, 0,        8'd0};

    p11 = fillPayload(1'b0, 8'h11);
    p22 = fillPayload(1'b0, 8'h22);
    p33 = fillPayload(1'b0, 8'h33);
    p5a = fillPayload(1'b0, 8'h5A);

    doReset();
    checkOutput("rst_valid", {31'd0, txIf.tx_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, txIf.tx_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_drop", {24'd0, dropCnt}, 32'd0);
    checkOutput("rst_lost", {31'd0, sigLost}, 32'd0);

    // Table-driven single frames with various ready patterns.
    for (int v = 0; v < 4; v++) begin
      pl = fillPayload(vecs[v].useIndex, vecs[v].fill);
      txIf.tx_ready = vecs[v].readyPat[0];
      applyStimulus(pl);
      checkOutput({vecs[v].name, "_lat_valid"}, {31'd0, txIf.tx_valid}, 32'd1);
      checkOutput({vecs[v].name, "_lat_data"}, {24'd0, txIf.tx_data}, 32'hAA);
      runStream(vecs[v].readyPat, 400, cyc);
      if (vecs[v].expCycles != 0) checkOutput({vecs[v].name, "_cycles"}, cyc, vecs[v].expCycles);
      checkOutput({vecs[v].name, "_busy_after"}, {31'd0, busy}, 32'd0);
      checkOutput({vecs[v].name, "_drop"}, {24'd0, dropCnt}, {24'd0, vecs[v].expDrop});
      buildExp(pl);
      checkFrames(vecs[v].name);
    end

    // Overrun: 22 and 33 arrive while frame 11 is in its payload.
    doReset();
    applyStimulus(p11);
    repeat (5) stepRec();
    checkOutput("ovr_at_idx3", {24'd0, txIf.tx_data}, 32'h11);
    applyStimulus(p22);
    checkOutput("ovr_drop0", {24'd0, dropCnt}, 32'd0);
    applyStimulus(p33);
    checkOutput("ovr_drop1", {24'd0, dropCnt}, 32'd1);
    runStream(4'b1111, 400, cyc);
    checkOutput("ovr_cycles", cyc, 2 * WIRE_LEN - 7);
    checkOutput("ovr_drop_end", {24'd0, dropCnt}, 32'd1);
    buildExp(p11);
    buildExp(p33);
    checkFrames("ovr");

    // Flag exactly on the final transfer edge, nothing pending.
    dropBefore = dropCnt;
    pl = fillPayload(1'b1, 8'h00);
    applyStimulus(pl);
    repeat (WIRE_LEN - 1) stepRec();
    checkOutput("col_last_valid", {31'd0, txIf.tx_valid}, 32'd1);
    applyStimulus(p5a);
    checkOutput("col_valid", {31'd0, txIf.tx_valid}, 32'd1);
    checkOutput("col_hdr0", {24'd0, txIf.tx_data}, 32'hAA);
    checkOutput("col_busy", {31'd0, busy}, 32'd1);
    checkOutput("col_drop", {24'd0, dropCnt}, {24'd0, dropBefore});
    runStream(4'b1111, 400, cyc);
    checkOutput("col_cycles", cyc, WIRE_LEN);
    buildExp(pl);
    buildExp(p5a);
    checkFrames("col");

`ifdef IRIG_FRAME_CHECKSUM_EN
    // Payload of all 01: checksum byte is AA^55^01 = FE.
    applyStimulus(fillPayload(1'b0, 8'h01));
    runStream(4'b1111, 400, cyc);
    checkOutput("csum_len", rxQ.size(), 28);
    if (rxQ.size() >= 28) checkOutput("csum_byte", {24'd0, rxQ[27]}, 32'hFE);
    rxQ.delete();
`endif

    // Loss monitor: asserts exactly at LOSS cycles, clears after a flag.
    doReset();
    repeat (99) stepRec();
    checkOutput("loss_99", {31'd0, sigLost}, 32'd0);
    stepRec();
    checkOutput("loss_100", {31'd0, sigLost}, 32'd1);
    repeat (5) stepRec();
    checkOutput("loss_hold", {31'd0, sigLost}, 32'd1);
    checkOutput("loss_no_tx", {31'd0, txIf.tx_valid}, 32'd0);
    applyStimulus(p22);
    checkOutput("loss_clear", {31'd0, sigLost}, 32'd0);
    runStream(4'b1111, 400, cyc);
    buildExp(p22);
    checkFrames("loss_frame");

    // Reset in the middle of the payload with a frame pending and a drop.
    applyStimulus(p11);
    repeat (4) stepRec();
    applyStimulus(p22);
    applyStimulus(p33);
    checkOutput("mid_drop_pre", {24'd0, dropCnt}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", {31'd0, txIf.tx_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_drop", {24'd0, dropCnt}, 32'd0);
    checkOutput("mid_rst_data", {24'd0, txIf.tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) stepRec();
    checkOutput("mid_no_pending", {31'd0, txIf.tx_valid}, 32'd0);
    rxQ.delete();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/irig_usb_frame_sched.md
Name: irig_usb_frame_sched

Overview:
- Sequences decoded IRIG-B time frames (25-byte array plus one-cycle frame-ready flag from the IRIG-B front end) onto the byte-wide USB transmit interface.
- Frames the payload with a 2-byte header and paces it with a valid/ready handshake.
- Provides one-deep frame buffering and counts dropped frames.
- Monitors loss of the time source.
- Sits between the IRIG-B processing block and the USB TX FIFO writer.

Parameters:
- FRAME_LEN, 25, payload bytes per frame (indices 0..FRAME_LEN-1).
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h55, second header byte.
- LOSS_CYCLES, 32'd75_000_000, clk cycles without a frame before loss is declared (1.5 s at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous reset, active-low.
- frame_array  in  8 x [FRAME_LEN-1:0]  time frame bytes; valid only in the cycle frame_flag=1.
- frame_flag  in  1  one-cycle pulse: frame_array holds a new frame.
- tx_data  out  8  byte to USB TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  USB side accepts the byte.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  8  saturating count of discarded frames.
- sig_lost  out  1  no frame seen for LOSS_CYCLES cycles.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-low on rst_n; it is sampled on the clk edge only.
- Reset values (also applied when reset is asserted mid-frame, with no completion of the frame in flight):
  - tx_data=0, tx_valid=0, busy=0, drop_cnt=0, sig_lost=0.
  - State=IDLE, shadow and pending buffers cleared, pend_vld=0, loss counter=0.
- Handshake:
  - A byte transfers on an edge where tx_valid&&tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - tx_valid never drops before its transfer.
- Capture:
  - On frame_flag in IDLE, frame_array is copied to the shadow buffer.
  - The next cycle shows state=HDR0, tx_valid=1, tx_data=HDR0, giving 1-cycle latency from flag to first valid byte.
- State machine:
  - IDLE -> HDR0 on frame_flag, or on pend_vld.
  - HDR0 -> HDR1 on transfer.
  - HDR1 -> BODY on transfer, with byte index idx=0.
  - BODY sends shadow[idx]; idx increments on each transfer.
  - On transfer of idx=FRAME_LEN-1, BODY -> CSUM if CHECKSUM_EN is defined, else -> end-of-frame.
  - CSUM -> end-of-frame on transfer.
- End-of-frame decision, evaluated on the edge of the final transfer:
  - If frame_flag is high on that edge: load frame_array into shadow and go to HDR0; pending is unchanged.
  - Else if pend_vld: move pending into shadow, clear pend_vld, go to HDR0.
  - Else: go to IDLE with tx_valid=0.
  - No idle bubble between back-to-back frames.
- Frame arriving while busy (frame_flag outside the final-transfer edge):
  - pend_vld=0: store frame in pending, set pend_vld.
  - pend_vld=1: overwrite pending with the newer frame; drop_cnt +1, saturating at 255.
  - If frame_flag arrives on the final-transfer edge while pend_vld=1: frame_flag wins and loads shadow; pending is kept for the next frame; no drop.
- Loss monitor:
  - Counter clears on every frame_flag, otherwise increments, saturating at LOSS_CYCLES.
  - sig_lost=1 while counter==LOSS_CYCLES.
  - sig_lost clears in the cycle after a frame_flag.
  - The monitor does not gate transmission.
- Frame length on the wire: 2+FRAME_LEN bytes (27), or 28 with CHECKSUM_EN.

Optional Feature:
- Macro IRIG_FRAME_CHECKSUM_EN.
- Defined:
  - CSUM state is present.
  - Appended byte = XOR of HDR0, HDR1 and all FRAME_LEN payload bytes, computed incrementally on each transfer.
  - Accumulator resets to 0 at each HDR0 entry.
- Undefined:
  - No CSUM state and no accumulator logic.
  - Frame ends after payload byte FRAME_LEN-1.

Test Plan:
- Single frame, tx_ready=1 always: frame_array[i]=i, one frame_flag pulse.
  - Expected: next cycle AA, then 55, then 00..18 on 27 consecutive cycles (checksum off); busy low 1 cycle after the last byte; drop_cnt=0.
- Backpressure: tx_ready toggling 1,0,0,1 repeatedly.
  - Expected: tx_data stable during every stall; the byte sequence is identical to the single-frame test; no duplicated or lost bytes.
- Overrun: 3 frame_flag pulses (payloads all 8'h11, 8'h22, 8'h33) while the first frame is at payload index 3, with tx_ready=1.
  - Expected: frame 11 completes, then frame 33 sent back-to-back; drop_cnt=1.
- Edge collision: frame_flag asserted exactly on the edge of the final payload transfer, pend_vld=0.
  - Expected: HDR0 asserted next cycle; no IDLE cycle; drop_cnt unchanged.
- Checksum (macro defined): payload all 8'h01, 25 bytes.
  - Expected: 28th byte = AA^55^01 = 8'hFE.
- Loss and reset (LOSS_CYCLES=100 in bench):
  - No frame for 100 cycles -> sig_lost=1; frame_flag -> sig_lost=0 next cycle.
  - rst_n=0 mid-BODY -> next cycle tx_valid=0, busy=0, drop_cnt=0.
